// File: rtl/mult_accumulator.sv
// mult_accumulator: control and accumulate stage of a sequential shift-add multiplier.
// Revision 1.0 - initial release.
`default_nettype none

module mult_accumulator #(
  parameter int DW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DW-1:0]     i_multiplicand,
  input  logic              i_lsb,
  output logic              o_load,
  output logic              o_busy,
  output logic              o_done,
  output logic [2*DW-1:0]   o_product
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     count;
  logic [2*DW-1:0]   acc;
  logic [2*DW-1:0]   mcand;
  logic [2*DW-1:0]   acc_sum;
  logic              last_bit;

  // Sum including this cycle's partial product, so the final add lands in o_product.
  assign acc_sum  = acc + (i_lsb ? mcand : '0);
  assign last_bit = (count == LAST_COUNT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_load     = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_next = LOAD;
      end
      LOAD: begin
        o_load     = 1'b1;
        o_busy     = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      o_product <= '0;
    end else begin
      case (state)
        LOAD: begin
          mcand <= {{DW{1'b0}}, i_multiplicand};
          acc   <= '0;
          count <= '0;
        end
        RUN: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          count <= count + 1'b1;
          if (last_bit) o_product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator: directed and random checks of mult_accumulator with a live shift-right stage.
// Revision 1.0 - initial release.
`default_nettype none

module tb_mult_accumulator;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   mcand_in = '0;
  logic [DW-1:0]   mplier_in = '0;
  logic            lsb;
  logic            load;
  logic            busy;
  logic            done;
  logic [2*DW-1:0] product;
  logic [DW-1:0]   sr;

  int n_checks = 0;
  int n_fail   = 0;

  int n_load, n_done, n_busy, done_k, load2_k, stable_viol;
  logic [2*DW-1:0] prod_at_done [2];
  logic [2*DW-1:0] prev_product;

  always #5 clk = ~clk;

  mult_accumulator #(.DW(DW)) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_start        (start),
    .i_multiplicand (mcand_in),
    .i_lsb          (lsb),
    .o_load         (load),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (product)
  );

  // Upstream shift-right stage: captures the multiplier on load, then shifts out LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sr <= '0;
    else if (load) sr <= mplier_in;
    else           sr <= sr >> 1;
  end
  assign lsb = sr[0];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Called at posedge+1. Raises start, observes `window` cycles, drops start after sample `hold`.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int hold, input int window, input bit inject);
    n_load = 0; n_done = 0; n_busy = 0; done_k = -1; load2_k = -1;
    prod_at_done[0] = '0; prod_at_done[1] = '0;
    start = 1'b1; mcand_in = a; mplier_in = b;
    for (int k = 1; k <= window; k++) begin
      @(posedge clk); #1;
      if (load) begin
        n_load++;
        if (n_load == 2) load2_k = k;
      end
      if (busy) n_busy++;
      if (done) begin
        if (n_done < 2) prod_at_done[n_done] = product;
        if (n_done == 0) done_k = k;
        n_done++;
      end else if (product !== prev_product) begin
        stable_viol++;
      end
      prev_product = product;
      if (k == hold) start = 1'b0;
      if (inject && k == 5) begin
        start = 1'b1; mcand_in = ~a; mplier_in = ~b;
      end
      if (inject && k == 6) start = 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2*DW-1:0] exp);
    run_op(a, b, 1, 14, 1'b0);
    check({tag, " product"}, prod_at_done[0], exp);
    check({tag, " done_pulses"}, n_done, 1);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;

    // Test 1: reset state, then 13 x 11
    repeat (2) @(posedge clk);
    #1;
    check("reset load", load, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    prev_product = product;
    run_op(8'd13, 8'd11, 1, 14, 1'b0);
    check("13x11 product", prod_at_done[0], 143);
    check("13x11 load_cycles", n_load, 1);
    check("13x11 done_latency", done_k, 10);
    check("13x11 done_pulses", n_done, 1);
    check("13x11 busy_cycles", n_busy, 9);
    check("13x11 product_held", product, 143);

    // Test 2: corner operands
    check_op("255x255", 8'd255, 8'd255, 16'd65025);
    check_op("0x200", 8'd0, 8'd200, 16'd0);
    check_op("200x0", 8'd200, 8'd0, 16'd0);
    check_op("1x1", 8'd1, 8'd1, 16'd1);

    // Test 3: start held high across two back-to-back operations
    run_op(8'd7, 8'd9, 12, 26, 1'b0);
    check("held loads", n_load, 2);
    check("held dones", n_done, 2);
    check("held first_done", done_k, 10);
    check("held second_load", load2_k, 12);
    check("held product0", prod_at_done[0], 63);
    check("held product1", prod_at_done[1], 63);

    // Test 4: start pulsed during RUN is ignored
    run_op(8'd21, 8'd3, 1, 14, 1'b1);
    check("ignore product", prod_at_done[0], 63);
    check("ignore loads", n_load, 1);
    check("ignore dones", n_done, 1);
    check("ignore busy_cycles", n_busy, 9);
    check("ignore done_latency", done_k, 10);

    // Test 5: async reset in the 4th RUN cycle
    start = 1'b1; mcand_in = 8'd50; mplier_in = 8'd50;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    check("prereset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort load", load, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort product", product, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("abort idle_no_done", n_done, 0);
    prev_product = product;
    check_op("5x6", 8'd5, 8'd6, 16'd30);

    // Test 6: random operands against a reference product
    stable_viol = 0;
    prev_product = product;
    for (int i = 0; i < 100; i++) begin
      ra = DW'($urandom_range(0, 255));
      rb = DW'($urandom_range(0, 255));
      check_op("random", ra, rb, 16'(ra) * 16'(rb));
    end
    check("random product_stable", stable_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
